// File: rtl/trisc_pkg.sv
// rtl/trisc_pkg.sv - shared TRISC loader types and sizing constants
package trisc_pkg;

    localparam int TRISC_DEPTH  = 16;
    localparam int TRISC_ADDR_W = 4;
    localparam int TRISC_DATA_W = 8;
    localparam int CSUM_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/loader_checksum.sv
// rtl/loader_checksum.sv - mod-2^W byte accumulator with clear/add and lookahead sum
module loader_checksum
    import trisc_pkg::*;
#(
    parameter int W = CSUM_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_add,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_value,
    output logic [W-1:0] o_next
);

    logic [W-1:0] r_acc;

    // o_next lets the owner compare against the sum including the current byte
    assign o_next  = r_acc + i_data;
    assign o_value = r_acc;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= o_next;
        end
    end

endmodule

// File: rtl/trisc_program_loader.sv
// rtl/trisc_program_loader.sv - loads the 16x8 TRISC program RAM from a byte stream and verifies it
module trisc_program_loader
    import trisc_pkg::*;
#(
    parameter int DEPTH  = TRISC_DEPTH,
    parameter int ADDR_W = TRISC_ADDR_W,
    parameter int DATA_W = TRISC_DATA_W
) (
    input  logic              SysClock,
    input  logic              Clear,
    input  logic              Start,
    input  logic              InValid,
    input  logic [DATA_W-1:0] InData,
    output logic              InReady,
    output logic [ADDR_W-1:0] RAMaddr,
    output logic [DATA_W-1:0] RAMdata,
    output logic              RAMwrite,
    input  logic [DATA_W-1:0] MDO,
    output logic              Owner,
    output logic              HoldCPU,
    output logic              Done,
    output logic              Error
);

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W:0]   r_vcnt;

    logic              w_accept;
    logic              w_clear_sums;
    logic              w_sum_add;
    logic              w_rsum_add;
    logic              w_owns;
    logic [CSUM_W-1:0] w_sum;
    logic [CSUM_W-1:0] w_sum_next;
    logic [CSUM_W-1:0] w_rsum;
    logic [CSUM_W-1:0] w_rsum_next;

    assign InReady  = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign w_accept = InValid && InReady;

    // ERROR keeps ownership so the processor can never start on a bad image
    assign w_owns = (w_next == ST_LOAD) || (w_next == ST_CHECK) ||
                    (w_next == ST_VERIFY) || (w_next == ST_ERROR);

    loader_checksum #(.W(CSUM_W)) u_load_sum (
        .i_clk   (SysClock),
        .i_rst   (Clear),
        .i_clear (w_clear_sums),
        .i_add   (w_sum_add),
        .i_data  (CSUM_W'(InData)),
        .o_value (w_sum),
        .o_next  (w_sum_next)
    );

    loader_checksum #(.W(CSUM_W)) u_read_sum (
        .i_clk   (SysClock),
        .i_rst   (Clear),
        .i_clear (w_clear_sums),
        .i_add   (w_rsum_add),
        .i_data  (CSUM_W'(MDO)),
        .o_value (w_rsum),
        .o_next  (w_rsum_next)
    );

    always_ff @(posedge SysClock) begin
        if (Clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_clear_sums = 1'b0;
        w_sum_add    = 1'b0;
        w_rsum_add   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (Start) begin
                    w_next       = ST_LOAD;
                    w_clear_sums = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_sum_add = 1'b1;
                    if (r_count == ADDR_W'(DEPTH - 1)) begin
                        w_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (w_accept) begin
                    w_next = (w_sum_next == '0) ? ST_VERIFY : ST_ERROR;
                end
            end
            ST_VERIFY: begin
                // MDO lags the address by one cycle, so the first sample is skipped
                if (r_vcnt != '0) begin
                    w_rsum_add = 1'b1;
                end
                if (r_vcnt == (ADDR_W + 1)'(DEPTH)) begin
                    w_next = (w_rsum_next == w_sum) ? ST_DONE : ST_ERROR;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge SysClock) begin
        if (Clear) begin
            RAMaddr  <= '0;
            RAMdata  <= '0;
            RAMwrite <= 1'b0;
            Owner    <= 1'b0;
            HoldCPU  <= 1'b0;
            Done     <= 1'b0;
            Error    <= 1'b0;
            r_count  <= '0;
            r_vcnt   <= '0;
        end else begin
            RAMwrite <= 1'b0;
            Owner    <= w_owns;
            HoldCPU  <= w_owns;
            Done     <= (w_next == ST_DONE);
            Error    <= (w_next == ST_ERROR);
            if (w_clear_sums) begin
                r_count <= '0;
            end
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        RAMaddr  <= r_count;
                        RAMdata  <= InData;
                        RAMwrite <= 1'b1;
                        r_count  <= r_count + ADDR_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (w_next == ST_VERIFY) begin
                        RAMaddr <= '0;
                        r_vcnt  <= '0;
                    end
                end
                ST_VERIFY: begin
                    r_vcnt <= r_vcnt + (ADDR_W + 1)'(1);
                    if (r_vcnt < (ADDR_W + 1)'(DEPTH - 1)) begin
                        RAMaddr <= r_vcnt[ADDR_W-1:0] + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/trisc_program_loader.md
# trisc_program_loader

Sequential loader that fills the 16×8 TRISC program RAM from a byte stream, then reads the RAM back to confirm the image. It replaces the manual DataIn/ClockIn/address-generator entry path. It sits directly upstream of the RAM and the processor:
- it owns the RAM address, data and write-enable while loading;
- it holds the processor in its stopped state until a verified image is present.

## Interface
- DEPTH, 16, program words loaded per image
- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM word width (opcode [7:4], operand [3:0])

Ports:
- SysClock  in  1  system clock, all logic on rising edge
- Clear  in  1  synchronous, active-high reset
- Start  in  1  pulse; begins a load when in IDLE, DONE or ERROR
- InValid  in  1  upstream byte valid
- InData  in  DATA_W  upstream byte
- InReady  out  1  loader accepts a byte this cycle when InValid&&InReady
- RAMaddr  out  ADDR_W  RAM address
- RAMdata  out  DATA_W  RAM write data
- RAMwrite  out  1  RAM write enable
- MDO  in  DATA_W  RAM read data, valid one cycle after RAMaddr
- Owner  out  1  loader drives RAM (selects RAMaddr/RAMdata/RAMwrite at the RAM muxes)
- HoldCPU  out  1  keeps processor startStop asserted
- Done  out  1  verified image present
- Error  out  1  checksum or readback failure

## Operation
- States: IDLE, LOAD, CHECK, VERIFY, DONE, ERROR.
- **IDLE**
  - Owner=0, HoldCPU=0, InReady=0.
  - Start → LOAD; clears count, sum and flags.
- **LOAD**
  - Owner=1, HoldCPU=1, InReady=1.
  - Each accepted byte b:
    - registered write next cycle: RAMaddr=count, RAMdata=b, RAMwrite=1;
    - sum += b (mod 256);
    - count++.
  - Back-to-back bytes are allowed, one write per cycle.
  - After the DEPTH-th accepted byte → CHECK.
- **CHECK**
  - InReady=1; accepts one checksum byte c.
  - (sum + c) mod 256 == 0 → VERIFY; otherwise → ERROR.
- **VERIFY**
  - InReady=0, RAMwrite=0.
  - Presents addresses 0..DEPTH-1 on consecutive cycles.
  - Accumulates rsum from MDO with one-cycle lag, so the state lasts DEPTH+1 cycles.
  - rsum == sum → DONE; otherwise → ERROR.
- **DONE**
  - Done=1, Owner=0, HoldCPU=0.
  - Start → LOAD.
- **ERROR**
  - Error=1, Owner=1, HoldCPU=1, so the processor never runs a bad image.
  - Start → LOAD.
- Start while in LOAD, CHECK or VERIFY is ignored.
- InValid while InReady=0 is not consumed; upstream must hold the byte.
- Counter and address wrap are impossible: the transition fires on count == DEPTH-1 acceptance.

## Timing
- Reset values (Clear): state=IDLE, InReady=0, RAMaddr=0, RAMdata=0, RAMwrite=0, Owner=0, HoldCPU=0, Done=0, Error=0, count=0, sum=0.
- All outputs are registered except InReady, which is decoded from state.
- Latency:
  - Start → LOAD: 1 cycle.
  - Byte accepted in cycle N → RAMwrite=1 in N+1.
  - Last data byte accepted → CHECK next cycle.
  - Checksum accepted → first VERIFY address next cycle.
  - Last MDO sampled → DONE/ERROR next cycle.
- Minimum load with InValid held high: 1 + DEPTH + 1 + (DEPTH+1) + 1 cycles = 36 for DEPTH=16.
- Clear mid-operation:
  - returns to IDLE next edge and deasserts RAMwrite in that cycle;
  - RAM contents are partial and unspecified;
  - Done=0.
- Clear and Start in the same cycle: Clear wins.

## Structure
- Shared package trisc_pkg:
  - loader state enum;
  - DEPTH/ADDR_W/DATA_W defaults, matching the RAM and PC widths;
  - checksum width constant.
- Sub-module loader_checksum: 8-bit mod-256 accumulator with clear/add/value. It is instantiated twice, for load sum and readback sum.
- The FSM, counter and output registers live in trisc_program_loader.

## Test plan
- Reset: assert Clear for 2 cycles mid-LOAD after 5 bytes → all outputs 0, state IDLE, RAMwrite low the cycle after Clear.
- Good image:
  - stimulus: Start, bytes 0x10..0x1F back-to-back, checksum 0x88 (sum 0x178 → 0x78, 0x78+0x88=0x100);
  - response: 16 writes at addr 0..15 with matching data, Done=1 at cycle 36, HoldCPU drops with Done.
- Bad checksum: same bytes with checksum 0x87 → ERROR, Error=1, HoldCPU stays 1, no VERIFY reads issued.
- Readback fault:
  - stimulus: RAM model forces MDO at addr 7 to 0x00;
  - response: ERROR after VERIFY, Done=0.
- Throttled input:
  - stimulus: InValid toggled every 3rd cycle;
  - response: exactly one write per accepted byte, no write without an accept, final Done=1.
- Start ignored mid-LOAD: Start pulse after byte 4 → count continues at 5, image still verifies; then Start in DONE → new LOAD with Done cleared next cycle.
